// File: rtl/v810_bus_pkg.sv
// Shared types and beat-planning helpers for the V810 bus-side memory controller.
package v810_bus_pkg;

  typedef enum logic [1:0] {
    DW8  = 2'd0,
    DW16 = 2'd1,
    DW32 = 2'd2
  } dw_t;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    ACK
  } state_t;

  // Pending-beat mask: bit k set means a beat starts at CPU byte lane k.
  function automatic logic [3:0] beat_plan(input dw_t dw, input logic [3:0] ben);
    logic [3:0] m;
    m = '0;
    case (dw)
      DW8:     m = ~ben;
      DW16:    m = {1'b0, ~&ben[3:2], 1'b0, ~&ben[1:0]};
      default: m = {3'b000, ~&ben};
    endcase
    return m;
  endfunction

  function automatic int unsigned beat_count(input dw_t dw, input logic [3:0] ben);
    return $countones(beat_plan(dw, ben));
  endfunction

  // Byte offset of the lowest pending beat.
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    logic [1:0] o;
    if (m[0])      o = 2'd0;
    else if (m[1]) o = 2'd1;
    else if (m[2]) o = 2'd2;
    else           o = 2'd3;
    return o;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] ben);
    return {{8{~ben[3]}}, {8{~ben[2]}}, {8{~ben[1]}}, {8{~ben[0]}}};
  endfunction

endpackage

// File: rtl/v810_mem_ctrl_if.sv
// V810 CPU-side bus pins as seen by the memory controller.
interface v810_mem_ctrl_if;
  logic [31:0] A;
  logic [31:0] D_O;
  logic [3:0]  BEn;
  logic        MRQn;
  logic        RW;
  logic        BCYSTn;
  logic [31:0] D_I;
  logic        READYn;
  logic        SZRQn;

  modport master (
    output A, D_O, BEn, MRQn, RW, BCYSTn,
    input  D_I, READYn, SZRQn
  );

  modport slave (
    input  A, D_O, BEn, MRQn, RW, BCYSTn,
    output D_I, READYn, SZRQn
  );
endinterface

// File: rtl/v810_lane_steer.sv
// Per-beat lane steering: CPU write lanes to region low lanes, region read data to CPU lanes.
module v810_lane_steer
  import v810_bus_pkg::*;
(
  input  dw_t         dw,
  input  logic [1:0]  off,
  input  logic [3:0]  ben,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] asm_in,
  output logic [3:0]  mem_nbe,
  output logic [31:0] mem_do,
  output logic [31:0] asm_out
);

  logic [4:0] sh8;
  logic [4:0] sh16;

  assign sh8  = {off, 3'b000};
  assign sh16 = {off[1], 4'b0000};

  always_comb begin
    mem_nbe = 4'hF;
    mem_do  = '0;
    asm_out = asm_in;
    case (dw)
      DW8: begin
        mem_nbe          = {3'b111, ben[off]};
        mem_do[7:0]      = wdata[sh8 +: 8];
        asm_out[sh8 +: 8] = rdata[7:0];
      end
      DW16: begin
        mem_nbe            = {2'b11, ben[{off[1], 1'b0} +: 2]};
        mem_do[15:0]       = wdata[sh16 +: 16];
        asm_out[sh16 +: 16] = rdata[15:0];
      end
      default: begin
        mem_nbe = ben;
        mem_do  = wdata;
        asm_out = rdata;
      end
    endcase
  end

endmodule

// File: rtl/v810_mem_ctrl.sv
// V810 bus-side memory controller: region decode, narrow-beat resizing, wait states, READYn.
module v810_mem_ctrl
  import v810_bus_pkg::*;
#(
  parameter int NREG = 4,
  parameter int WSW  = 4
) (
  input  logic                      CLK,
  input  logic                      RESn,
  input  logic                      CE,
  v810_mem_ctrl_if.slave            bus,
  input  logic [NREG-1:0][31:0]     REG_BASE,
  input  logic [NREG-1:0][31:0]     REG_MASK,
  input  logic [NREG-1:0][WSW-1:0]  REG_WS,
  input  dw_t  [NREG-1:0]           REG_DW,
  output logic [NREG-1:0]           MEM_nCE,
  output logic                      MEM_nWE,
  output logic [31:0]               MEM_A,
  output logic [3:0]                MEM_nBE,
  output logic [31:0]               MEM_DO,
  input  logic [NREG-1:0][31:0]     MEM_DI,
  output logic                      ERR
);

  localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t          state_q, state_d;
  logic [31:2]     a_q;
  logic            rw_q;
  logic [3:0]      ben_q;
  logic [31:0]     do_q;
  logic [RIW-1:0]  ridx_q;
  logic [WSW-1:0]  ws_q, wcnt_q;
  dw_t             dw_q;
  logic [3:0]      pend_q;
  logic [31:0]     asm_q;
  logic            err_q;

  logic            hit;
  logic [RIW-1:0]  hit_idx;
  logic [3:0]      plan;
  logic            start;
  logic [1:0]      off;
  logic [3:0]      cur_bit;
  logic            last;
  logic [3:0]      st_nbe;
  logic [31:0]     st_do;
  logic [31:0]     asm_nxt;

  // Lowest-index matching region wins on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!hit && ((bus.A & REG_MASK[i]) == REG_BASE[i])) begin
        hit     = 1'b1;
        hit_idx = RIW'(i);
      end
    end
  end

  assign plan    = beat_plan(REG_DW[hit_idx], bus.BEn);
  assign start   = CE && (state_q == IDLE) && !bus.BCYSTn && !bus.MRQn;
  assign off     = first_lane(pend_q);
  assign cur_bit = 4'b0001 << off;
  assign last    = (pend_q & ~cur_bit) == '0;

  v810_lane_steer u_steer (
    .dw      (dw_q),
    .off     (off),
    .ben     (ben_q),
    .wdata   (do_q),
    .rdata   (MEM_DI[ridx_q]),
    .asm_in  (asm_q),
    .mem_nbe (st_nbe),
    .mem_do  (st_do),
    .asm_out (asm_nxt)
  );

  always_ff @(posedge CLK) begin
    if (!RESn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (hit && plan != '0) ? BEAT : ACK;
      BEAT: if (CE && wcnt_q == '0 && last) state_d = ACK;
      ACK:  if (CE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      a_q    <= '0;
      rw_q   <= 1'b1;
      ben_q  <= '1;
      do_q   <= '0;
      ridx_q <= '0;
      ws_q   <= '0;
      wcnt_q <= '0;
      dw_q   <= DW32;
      pend_q <= '0;
      asm_q  <= '0;
      err_q  <= 1'b0;
    end else if (CE) begin
      case (state_q)
        IDLE: if (start) begin
          a_q    <= bus.A[31:2];
          rw_q   <= bus.RW;
          ben_q  <= bus.BEn;
          do_q   <= bus.D_O;
          ridx_q <= hit_idx;
          ws_q   <= REG_WS[hit_idx];
          wcnt_q <= REG_WS[hit_idx];
          dw_q   <= REG_DW[hit_idx];
          pend_q <= hit ? plan : '0;
          asm_q  <= '0;
          if (!hit) err_q <= 1'b1;
        end
        BEAT: begin
          if (wcnt_q != '0) begin
            wcnt_q <= wcnt_q - 1'b1;
          end else begin
            asm_q  <= asm_nxt;
            pend_q <= pend_q & ~cur_bit;
            wcnt_q <= ws_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    MEM_nCE    = '1;
    MEM_nWE    = 1'b1;
    MEM_A      = '0;
    MEM_nBE    = 4'hF;
    MEM_DO     = '0;
    bus.D_I    = '0;
    bus.READYn = 1'b1;
    bus.SZRQn  = 1'b1;
    if (state_q == BEAT) begin
      MEM_nCE = ~(NREG'(1) << ridx_q);
      MEM_nWE = rw_q;
      MEM_A   = {a_q, off};
      MEM_nBE = st_nbe;
      MEM_DO  = st_do;
    end
    if (state_q == ACK) begin
      bus.READYn = 1'b0;
      bus.D_I    = asm_q & lane_mask(ben_q);
    end
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_v810_mem_ctrl.sv
// Directed self-checking bench for v810_mem_ctrl with four decoded regions.
module tb_v810_mem_ctrl;
  import v810_bus_pkg::*;

  logic clk;
  logic resn;
  logic ce;
  logic [3:0][31:0] reg_base;
  logic [3:0][31:0] reg_mask;
  logic [3:0][3:0]  reg_ws;
  dw_t  [3:0]       reg_dw;
  logic [3:0]       mem_nce;
  logic             mem_nwe;
  logic [31:0]      mem_a;
  logic [3:0]       mem_nbe;
  logic [31:0]      mem_do;
  logic [3:0][31:0] mem_di;
  logic             err;

  int total = 0;
  int bad   = 0;

  v810_mem_ctrl_if bus ();

  v810_mem_ctrl #(.NREG(4), .WSW(4)) dut (
    .CLK      (clk),
    .RESn     (resn),
    .CE       (ce),
    .bus      (bus),
    .REG_BASE (reg_base),
    .REG_MASK (reg_mask),
    .REG_WS   (reg_ws),
    .REG_DW   (reg_dw),
    .MEM_nCE  (mem_nce),
    .MEM_nWE  (mem_nwe),
    .MEM_A    (mem_a),
    .MEM_nBE  (mem_nbe),
    .MEM_DO   (mem_do),
    .MEM_DI   (mem_di),
    .ERR      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one bus cycle for a single edge; returns in the first cycle after it.
  task automatic start(input logic [31:0] a, input logic rw, input logic [3:0] ben,
                       input logic [31:0] d);
    bus.A      = a;
    bus.RW     = rw;
    bus.BEn    = ben;
    bus.D_O    = d;
    bus.BCYSTn = 1'b0;
    bus.MRQn   = 1'b0;
    step();
    bus.BCYSTn = 1'b1;
    bus.MRQn   = 1'b1;
  endtask

  initial begin
    resn = 1'b0;
    ce   = 1'b1;
    bus.A = '0; bus.D_O = '0; bus.BEn = '1; bus.RW = 1'b1;
    bus.MRQn = 1'b1; bus.BCYSTn = 1'b1;
    reg_base[0] = 32'h0000_0000; reg_mask[0] = 32'h8000_0000; reg_ws[0] = 4'd0; reg_dw[0] = DW32;
    reg_base[1] = 32'hFFF0_0000; reg_mask[1] = 32'hFFF0_0000; reg_ws[1] = 4'd1; reg_dw[1] = DW16;
    reg_base[2] = 32'h0000_0000; reg_mask[2] = 32'hFFFF_0000; reg_ws[2] = 4'd2; reg_dw[2] = DW16;
    reg_base[3] = 32'hC000_0000; reg_mask[3] = 32'hF000_0000; reg_ws[3] = 4'd1; reg_dw[3] = DW8;
    mem_di[0] = 32'h1122_3344;
    mem_di[1] = 32'hDEAD_AAAA;
    mem_di[2] = 32'h9999_9999;
    mem_di[3] = 32'h0000_0000;

    step(); step();
    chk("rst_readyn", {31'd0, bus.READYn}, 32'd1);
    chk("rst_szrqn",  {31'd0, bus.SZRQn},  32'd1);
    chk("rst_nce",    {28'd0, mem_nce},    32'hF);
    chk("rst_nwe",    {31'd0, mem_nwe},    32'd1);
    chk("rst_nbe",    {28'd0, mem_nbe},    32'hF);
    chk("rst_a",      mem_a,               32'h0);
    chk("rst_do",     mem_do,              32'h0);
    chk("rst_di",     bus.D_I,             32'h0);
    chk("rst_err",    {31'd0, err},        32'd0);
    resn = 1'b1;
    step();

    // DW32, WS0 word read
    start(32'h0000_0100, 1'b1, 4'b0000, 32'h0);
    chk("w32_nce",    {28'd0, mem_nce},    32'hE);
    chk("w32_a",      mem_a,               32'h0000_0100);
    chk("w32_nwe",    {31'd0, mem_nwe},    32'd1);
    chk("w32_nbe",    {28'd0, mem_nbe},    32'h0);
    chk("w32_rdy1",   {31'd0, bus.READYn}, 32'd1);
    step();
    chk("w32_rdy2",   {31'd0, bus.READYn}, 32'd0);
    chk("w32_di",     bus.D_I,             32'h1122_3344);
    step();
    chk("w32_rdy3",   {31'd0, bus.READYn}, 32'd1);
    chk("w32_di0",    bus.D_I,             32'h0);

    // DW16, WS1 word read: two halfword beats
    start(32'hFFF0_0010, 1'b1, 4'b0000, 32'h0);
    chk("h16_a0",     mem_a,               32'hFFF0_0010);
    chk("h16_nce",    {28'd0, mem_nce},    32'hD);
    chk("h16_nbe0",   {28'd0, mem_nbe},    32'hC);
    step();
    chk("h16_a0b",    mem_a,               32'hFFF0_0010);
    step();
    mem_di[1] = 32'hDEAD_BBBB;
    chk("h16_a1",     mem_a,               32'hFFF0_0012);
    chk("h16_nbe1",   {28'd0, mem_nbe},    32'hC);
    chk("h16_rdy3",   {31'd0, bus.READYn}, 32'd1);
    step();
    chk("h16_rdy4",   {31'd0, bus.READYn}, 32'd1);
    step();
    chk("h16_rdy5",   {31'd0, bus.READYn}, 32'd0);
    chk("h16_di",     bus.D_I,             32'hBBBB_AAAA);
    step();

    // DW8, WS1 write of two bytes; a stray BCYSTn mid-access is ignored
    start(32'hC000_0040, 1'b0, 4'b0101, 32'hAABB_CCDD);
    chk("b8_a0",      mem_a,               32'hC000_0041);
    chk("b8_do0",     mem_do,              32'h0000_00CC);
    chk("b8_nbe0",    {28'd0, mem_nbe},    32'hE);
    chk("b8_nwe",     {31'd0, mem_nwe},    32'd0);
    chk("b8_nce",     {28'd0, mem_nce},    32'h7);
    bus.A = 32'h0000_0000; bus.BCYSTn = 1'b0; bus.MRQn = 1'b0;
    step();
    bus.BCYSTn = 1'b1; bus.MRQn = 1'b1;
    chk("b8_a0b",     mem_a,               32'hC000_0041);
    step();
    chk("b8_a1",      mem_a,               32'hC000_0043);
    chk("b8_do1",     mem_do,              32'h0000_00AA);
    chk("b8_nbe1",    {28'd0, mem_nbe},    32'hE);
    step();
    chk("b8_rdy4",    {31'd0, bus.READYn}, 32'd1);
    step();
    chk("b8_rdy5",    {31'd0, bus.READYn}, 32'd0);
    step();
    chk("b8_rdy6",    {31'd0, bus.READYn}, 32'd1);
    chk("b8_nce6",    {28'd0, mem_nce},    32'hF);

    // Unmapped access
    chk("err_pre",    {31'd0, err},        32'd0);
    start(32'hA000_0000, 1'b1, 4'b0000, 32'h0);
    chk("um_rdy",     {31'd0, bus.READYn}, 32'd0);
    chk("um_di",      bus.D_I,             32'h0);
    chk("um_err",     {31'd0, err},        32'd1);
    chk("um_nce",     {28'd0, mem_nce},    32'hF);
    step();
    chk("um_rdy2",    {31'd0, bus.READYn}, 32'd1);
    chk("um_err2",    {31'd0, err},        32'd1);

    // Overlapping regions 0 and 2: region 0 wins; upper-half read
    start(32'h0000_0200, 1'b1, 4'b0011, 32'h0);
    chk("ov_nce",     {28'd0, mem_nce},    32'hE);
    chk("ov_nbe",     {28'd0, mem_nbe},    32'h3);
    step();
    chk("ov_rdy",     {31'd0, bus.READYn}, 32'd0);
    chk("ov_di",      bus.D_I,             32'h1122_0000);
    step();

    // No byte enabled: zero-beat completion
    start(32'h0000_0300, 1'b1, 4'b1111, 32'h0);
    chk("zb_rdy",     {31'd0, bus.READYn}, 32'd0);
    chk("zb_di",      bus.D_I,             32'h0);
    chk("zb_nce",     {28'd0, mem_nce},    32'hF);
    chk("zb_err",     {31'd0, err},        32'd1);
    step();

    // DW8 read: CE freeze, then reset during beat 1
    start(32'hC000_0000, 1'b1, 4'b0000, 32'h0);
    chk("fz_a0",      mem_a,               32'hC000_0000);
    ce = 1'b0;
    step(); step(); step();
    chk("fz_a",       mem_a,               32'hC000_0000);
    chk("fz_nce",     {28'd0, mem_nce},    32'h7);
    chk("fz_rdy",     {31'd0, bus.READYn}, 32'd1);
    ce = 1'b1;
    step();
    chk("fz_a0c",     mem_a,               32'hC000_0000);
    step();
    chk("fz_a1",      mem_a,               32'hC000_0001);
    chk("fz_nbe1",    {28'd0, mem_nbe},    32'hE);
    resn = 1'b0;
    step();
    chk("mr_readyn",  {31'd0, bus.READYn}, 32'd1);
    chk("mr_nce",     {28'd0, mem_nce},    32'hF);
    chk("mr_nwe",     {31'd0, mem_nwe},    32'd1);
    chk("mr_nbe",     {28'd0, mem_nbe},    32'hF);
    chk("mr_a",       mem_a,               32'h0);
    chk("mr_do",      mem_do,              32'h0);
    chk("mr_di",      bus.D_I,             32'h0);
    chk("mr_err",     {31'd0, err},        32'd0);
    resn = 1'b1;
    step();
    chk("mr_rdy1",    {31'd0, bus.READYn}, 32'd1);
    step();
    chk("mr_rdy2",    {31'd0, bus.READYn}, 32'd1);
    chk("mr_nce2",    {28'd0, mem_nce},    32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v810_mem_ctrl.md
# v810_mem_ctrl

Parametrised V810 bus-side memory controller: replaces the per-testbench glue of address decode, single resizer and hand-built READYn/SZRQn logic. Decodes each CPU bus cycle into one of NREG regions, runs the access as one or more narrow beats sized to the region's data width with per-region wait states, and returns a single 32-bit completion to the CPU. Sits between the `v810` core bus pins and the `ram` instances / ROM models.

## Interface
- NREG, 4: number of decoded regions (1..8)
- WSW, 4: width of per-region wait-state count
- CLK  in  1  system clock
- RESn  in  1  reset, synchronous, active-low
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1, except reset
- A  in  32  CPU byte address
- D_O  in  32  CPU write data
- BEn  in  4  CPU byte enables, active-low
- MRQn, RW, BCYSTn  in  1 each  CPU memory request, read(1)/write(0), bus-cycle start
- D_I  out  32  read data to CPU
- READYn  out  1  cycle completion to CPU
- SZRQn  out  1  tied high; resizing is internal
- REG_BASE, REG_MASK  in  NREG×32  region matches when (A & REG_MASK) == REG_BASE
- REG_WS  in  NREG×WSW  wait states per beat
- REG_DW  in  NREG×2  region width, dw_t: DW8, DW16, DW32
- MEM_nCE  out  NREG  one-hot-low region chip enable
- MEM_nWE  out  1  low on write beats
- MEM_A  out  32  byte address of current beat
- MEM_nBE  out  4  beat byte enables, region-lane aligned
- MEM_DO  out  32  write data, steered to region lanes
- MEM_DI  in  NREG×32  read data per region
- ERR  out  1  sticky: an unmapped access occurred

## Operation
- States: IDLE, BEAT, ACK.
- IDLE: on CE with BCYSTn=0 and MRQn=0, latch A, RW, BEn, D_O, decoded region (lowest matching index wins), its WS and DW. Build beat list from enabled lanes: DW32 → one beat; DW16 → one beat per halfword with any BEn low; DW8 → one beat per enabled byte, ascending address. Go BEAT.
- No match, or BEn=4'b1111: no memory activity; go ACK directly, D_I=0; unmapped also sets ERR.
- BEAT: MEM_nCE[r]=0, MEM_A={A[31:2], beat offset}, MEM_nWE=RW. Wait counter loads WS at beat start, decrements per CE; at zero, capture MEM_DI[r] low lanes (DW8: [7:0]; DW16: [15:0]; DW32: all) into assembly register at the beat's CPU lane. Next beat, or ACK after last.
- Narrow write: beat lane of D_O moved to MEM_DO low lanes; MEM_nBE = beat's BEn bits in low positions, unused bits 1. DW32: MEM_nBE=BEn, MEM_DO=D_O.
- ACK: READYn=0, D_I=assembled data (unenabled lanes 0) for one CE cycle, then IDLE.
- BCYSTn while not IDLE ignored. REG_* sampled only in IDLE at cycle start.

## Timing
- Reset values: READYn=1, SZRQn=1, MEM_nCE all 1, MEM_nWE=1, MEM_nBE=4'hF, MEM_A=0, MEM_DO=0, D_I=0, ERR=0, state IDLE.
- BCYSTn sampled at CE cycle n; beats occupy cycles n+1 onward, each WS+1 CE cycles; READYn low in CE cycle n+1+B·(WS+1), B = beat count. Zero-beat completion: READYn low in n+1.
- MEM_nCE high for one CE cycle between beats is not required; it stays low across consecutive beats of one access.
- Reset mid-access abandons it; outputs return to reset values on that edge; no READYn issued.
- CE=0 freezes all outputs.

## Structure
- `v810_bus_pkg`: dw_t enum, state enum, beat-count/offset function from DW and BEn.
- Sub-module `v810_lane_steer`: combinational write-data/BEn steering and read-data placement per beat; controller holds FSM, counter, assembly register.

## Test plan
- Region0 base 0, mask 0x8000_0000, DW32, WS0; read 0x100, BEn 0 → READYn low at n+2, D_I = MEM_DI[0] word.
- Region1 base 0xFFF0_0000, mask 0xFFF0_0000, DW16, WS1; word read 0xFFF0_0010 → two beats MEM_A 0x..10, 0x..12, READYn at n+5, D_I = {hi half, lo half}.
- DW8 region, write 0xAABBCCDD BEn 4'b0101 → beats at +1 (0xCC) and +3 (0xAA) on MEM_DO[7:0], MEM_nBE 4'b1110.
- Address matching no region → READYn at n+1, D_I 0, ERR stays 1 until reset.
- Overlapping regions 0 and 2 → only MEM_nCE[0] asserts.
- RESn low during beat 1 of DW8 access → next edge all outputs at reset values, no READYn.
